// File: rtl/bs_kmul.sv
// Bit-serial multiply-by-constant (q = K*a), LSB first, framed by a one-cycle sync pulse.
// Defining BS_KMUL_ACC_EN adds a serial addend input c, giving q = K*a + c.
module bs_kmul #(
  parameter int ILEN = 10,
  parameter int K    = 3,
  parameter int KW   = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic sync,
`ifdef BS_KMUL_ACC_EN
  input  logic c,
`endif
  input  logic a,
  output logic q,
  output logic q_sync,
  output logic q_last,
  output logic busy,
  output logic trunc
);

`ifdef BS_KMUL_ACC_EN
  localparam int CW = KW + 1;
`else
  localparam int CW = KW;
`endif
  localparam int OLEN = ILEN + CW;
  localparam int CNTW = $clog2(OLEN + 1);
  localparam int HW   = (KW > 1) ? KW - 1 : 1;
  localparam int SW   = CW + 2;
  localparam logic [KW-1:0] KV = KW'(K);

  logic [CNTW-1:0] cnt_q, cnt_d, cnt_eff;
  logic [HW-1:0]   hist_q, hist_d, hist_eff, hist_shift;
  logic [CW-1:0]   carry_q, carry_d, carry_eff;
  logic [KW-1:0]   h;
  logic [SW-1:0]   s;
  logic            active, in_range, last, ae;
  logic            q_q, q_d, q_sync_q, q_sync_d, q_last_q, q_last_d;
  logic            busy_q, busy_d, trunc_q, trunc_d;

  // cnt_q is 0 when idle and 1..OLEN-1 mid-word; a sync cycle always counts as bit 0.
  assign cnt_eff   = sync ? '0 : cnt_q;
  assign active    = sync || (cnt_q != '0);
  assign in_range  = cnt_eff < CNTW'(ILEN);
  assign last      = active && (cnt_eff == CNTW'(OLEN - 1));
  assign ae        = active && in_range && a;
  assign hist_eff  = sync ? '0 : hist_q;
  assign carry_eff = sync ? '0 : carry_q;

  // h[j] is the masked operand delayed j cycles.
  assign h[0]          = ae;
  assign hist_shift[0] = ae;
  generate
    for (genvar gi = 1; gi < KW; gi++) begin : g_hist
      assign h[gi] = hist_eff[gi-1];
    end
    for (genvar gi = 1; gi < HW; gi++) begin : g_shift
      assign hist_shift[gi] = hist_eff[gi-1];
    end
  endgenerate

  always_comb begin
    s = SW'(carry_eff);
    for (int j = 0; j < KW; j++) begin
      if (KV[j]) s = s + SW'(h[j]);
    end
`ifdef BS_KMUL_ACC_EN
    s = s + SW'(active && in_range && c);
`endif
  end

  always_comb begin
    hist_d   = '0;
    carry_d  = '0;
    cnt_d    = '0;
    q_d      = 1'b0;
    q_sync_d = sync;
    q_last_d = last;
    busy_d   = active;
    trunc_d  = sync && (cnt_q != '0);
    if (active) begin
      hist_d  = hist_shift;
      carry_d = s[CW:1];
      q_d     = s[0];
      if (sync)       cnt_d = CNTW'(1);
      else if (!last) cnt_d = cnt_q + CNTW'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q    <= '0;
      hist_q   <= '0;
      carry_q  <= '0;
      q_q      <= 1'b0;
      q_sync_q <= 1'b0;
      q_last_q <= 1'b0;
      busy_q   <= 1'b0;
      trunc_q  <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      hist_q   <= hist_d;
      carry_q  <= carry_d;
      q_q      <= q_d;
      q_sync_q <= q_sync_d;
      q_last_q <= q_last_d;
      busy_q   <= busy_d;
      trunc_q  <= trunc_d;
    end
  end

  assign q      = q_q;
  assign q_sync = q_sync_q;
  assign q_last = q_last_q;
  assign busy   = busy_q;
  assign trunc  = trunc_q;

endmodule

// File: doc/bs_kmul.md
Name: bs_kmul

Overview:
- Parametrised bit-serial multiply-by-constant for the modmul_bs datapath, LSB-first, word-framed by a one-cycle sync pulse.
- Computes q = K * a over an ILEN-bit serial operand and emits an OLEN = ILEN+KW bit serial product.
- Sits between a piso operand source and a sipo/reduction stage.
- Generalises the fixed x3 cell: arbitrary constant, word-length framing with internal zero padding, end-of-word and truncation flags, optional serial addend.

Parameters:
- ILEN, 10, operand word length in bits.
- K, 3, constant multiplier, K >= 1.
- KW, 2, bit width of K; K < 2^KW required.
- OLEN (localparam), ILEN+KW, product word length in bits.
- CNTW (localparam), clog2(OLEN+1), bit counter width.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-high reset.
- sync  in  1  one-cycle pulse, coincident with bit 0 (LSB) of a new operand word.
- a  in  1  serial operand, LSB first.
- q  out  1  serial product, LSB first, registered.
- q_sync  out  1  high with product bit 0.
- q_last  out  1  high with product bit OLEN-1.
- busy  out  1  high while product bits are being emitted.
- trunc  out  1  one-cycle pulse: previous word abandoned by an early sync.

Behaviour:
- Reset (async, active-high): q, q_sync, q_last, busy, trunc = 0. History shift register (KW-1 bits), carry register (KW bits) and bit counter cleared.
- Effective input bit: ae = a while counter < ILEN; ae = 0 otherwise. Zero padding is generated internally; upstream padding is not required.
- Per-cycle sum: s = sum over j of K[j]*h[j] + carry, where h[0] = ae and h[j] = ae delayed j cycles.
  - Output bit = s[0]; next carry = s >> 1.
  - carry <= K-1, so KW bits suffice.
- On a sync cycle, history and carry are treated as 0 in the sum (fresh word). The counter reloads to 1; otherwise it increments while busy.
- Latency: sync at cycle t0 gives product bit i at t0+1+i, for i = 0..OLEN-1.
  - q_sync = 1 at t0+1.
  - q_last = 1 at t0+OLEN.
  - busy = 1 from t0+1 through t0+OLEN.
- After bit OLEN-1: busy drops, q = 0, state held cleared; a is ignored until the next sync.
- Back-to-back words: sync at t0+OLEN is legal. The new bit 0 follows q_last with no gap and trunc stays 0.
- Early sync (counter < OLEN while busy):
  - Old word abandoned; state restarts as above.
  - trunc = 1 for one cycle, aligned with the new q_sync.
  - No q_last for the abandoned word.
- sync while idle: normal start, trunc = 0.
- Reset mid-word: outputs drop to 0 immediately. No q_last/trunc for that word.

Optional Feature:
- Macro BS_KMUL_ACC_EN.
- Defined:
  - Adds input port c (1 bit, serial addend, LSB first, aligned with a).
  - c is masked like a beyond ILEN. c enters s as an extra term, so q = K*a + c.
  - Carry register widens to KW+1 bits; OLEN becomes ILEN+KW+1.
- Undefined: no c port; q = K*a; widths as above.

Test Plan:
- K=3, KW=2, ILEN=10; sync + a=0x3FF LSB first -> 12-bit q word = 0xBFD; q_sync at t0+1, q_last at t0+12.
- K=3; a=0x155 then a=0x000 back-to-back (sync period 12) -> q = 0x3FF then 0x000; trunc never asserted.
- K=5, KW=3, ILEN=10; a=0x3FF with a held high past bit 9 -> q = 0x13FB (13 bits), proving input masking.
- K=3; sync, then a second sync 5 cycles later with a=0x001 -> trunc pulse with the new q_sync; q = 0x003; no q_last for the first word.
- Reset asserted at bit 6 of a=0x2AA word -> q, busy, q_sync, q_last go 0 asynchronously; the next sync with a=0x002 gives q = 0x006.
- BS_KMUL_ACC_EN, K=3: a=0x3FF, c=0x3FF -> 13-bit q = 0xFFC.
